// File: rtl/cpu_pkg.sv
// Shared MIPS decode constants and ID-stage FSM state type.
// Source-use decode helpers are shared by the hazard logic.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } id_state_t;

   function automatic logic uses_rs(input logic [5:0] op);
      return !(op == OP_J || op == OP_JAL || op == OP_LUI);
   endfunction

   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE ||
              op == OP_SB    || op == OP_SH  || op == OP_SW);
   endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Fetch->ID and ID->EX valid/ready handshake bundle.
// master drives the stage inputs, slave is the decode stage itself.
interface decode_operand_stage_if #(parameter int DATA_W = 32);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_instr;
   logic [DATA_W-1:0] in_pc;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_instr;
   logic [DATA_W-1:0] out_rs_val;
   logic [DATA_W-1:0] out_rt_val;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_rs_val, out_rt_val
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_rs_val, out_rt_val
   );

endinterface

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand: $0, then EX bypass, then WB bypass, then RF data.
// Purely combinational; a load in EX never bypasses because its data is not ready.
module operand_bypass_mux #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] rf_rd,
   input  logic              ex_we,
   input  logic [ADDR_W-1:0] ex_wa,
   input  logic [DATA_W-1:0] ex_wd,
   input  logic              ex_is_load,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   output logic [DATA_W-1:0] val
);

   always_comb begin
      val = rf_rd;
      if (idx == '0)
         val = '0;
      else if (ex_we && !ex_is_load && ex_wa == idx)
         val = ex_wd;
      else if (wb_we && wb_wa == idx)
         val = wb_wd;
   end

endmodule

// File: rtl/decode_operand_stage.sv
// MIPS ID stage: operand bypass, load-use stall, ID/EX register. Stall counter under ID_STALL_COUNT_EN.
// Latency 1 cycle accept->out_valid; one bubble per load-use hazard.
// Backpressure: holds everything while out_valid & !out_ready; flush kills held and incoming instr.
module decode_operand_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   decode_operand_stage_if.slave   pipe,
   output logic [ADDR_W-1:0]       rf_ra1,
   output logic [ADDR_W-1:0]       rf_ra2,
   input  logic [DATA_W-1:0]       rf_rd1,
   input  logic [DATA_W-1:0]       rf_rd2,
   input  logic                    ex_we,
   input  logic [ADDR_W-1:0]       ex_wa,
   input  logic [DATA_W-1:0]       ex_wd,
   input  logic                    ex_is_load,
   input  logic                    wb_we,
   input  logic [ADDR_W-1:0]       wb_wa,
   input  logic [DATA_W-1:0]       wb_wd,
   input  logic                    flush,
   output logic [31:0]             stall_count
);

   logic [5:0]        opcode;
   logic [ADDR_W-1:0] rs, rt;
   logic [DATA_W-1:0] rs_val, rt_val;
   logic              hazard, advance, accept;
   id_state_t         state;

   assign opcode = pipe.in_instr[DATA_W-1 -: 6];
   assign rs     = pipe.in_instr[RS_LSB +: ADDR_W];
   assign rt     = pipe.in_instr[RT_LSB +: ADDR_W];
   assign rf_ra1 = rs;
   assign rf_ra2 = rt;

   operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_mux (
      .idx(rs), .rf_rd(rf_rd1),
      .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .val(rs_val)
   );

   operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_mux (
      .idx(rt), .rf_rd(rf_rd2),
      .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .val(rt_val)
   );

   assign hazard  = pipe.in_valid && ex_we && ex_is_load && (ex_wa != '0) &&
                    ((uses_rs(opcode) && ex_wa == rs) || (uses_rt(opcode) && ex_wa == rt));
   assign advance = !pipe.out_valid || pipe.out_ready;
   assign pipe.in_ready = advance && !hazard && !flush;
   assign accept  = pipe.in_valid && pipe.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= RUN;
         pipe.out_valid  <= 1'b0;
         pipe.out_pc     <= '0;
         pipe.out_instr  <= '0;
         pipe.out_rs_val <= '0;
         pipe.out_rt_val <= '0;
`ifdef ID_STALL_COUNT_EN
         stall_count     <= '0;
`endif
      end else begin
         if (flush) begin
            state          <= RUN;
            pipe.out_valid <= 1'b0;
         end else if (advance) begin
            pipe.out_valid <= accept;
            case (state)
               RUN:     if (hazard) state <= STALL;
               // the load's data now comes via WB; a fresh load in EX re-stalls
               STALL:   state <= hazard ? STALL : RUN;
               default: state <= RUN;
            endcase
`ifdef ID_STALL_COUNT_EN
            if (hazard) stall_count <= stall_count + 32'd1;
`endif
         end
         if (accept) begin
            pipe.out_pc     <= pipe.in_pc;
            pipe.out_instr  <= pipe.in_instr;
            pipe.out_rs_val <= rs_val;
            pipe.out_rt_val <= rt_val;
         end
      end
   end

`ifndef ID_STALL_COUNT_EN
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed + random bench for decode_operand_stage against a cycle-level reference model.
module tb_decode_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        ex_we, ex_is_load, wb_we, flush;
   logic [4:0]  ex_wa, wb_wa;
   logic [31:0] ex_wd, wb_wd;
   logic [31:0] stall_count;
   logic [31:0] rf [32];

   int total = 0;
   int bad   = 0;

   logic        exp_valid;
   logic [31:0] exp_pc, exp_instr, exp_rs, exp_rt, exp_cnt;

   decode_operand_stage_if #(.DATA_W(32)) pipe ();

   decode_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .pipe(pipe),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .flush(flush), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   assign rf_rd1 = rf[rf_ra1];
   assign rf_rd2 = rf[rf_ra2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic m_uses_rs(input logic [5:0] op);
      return !(op inside {6'h02, 6'h03, 6'h0F});
   endfunction

   function automatic logic m_uses_rt(input logic [5:0] op);
      return op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
   endfunction

   function automatic logic [31:0] m_operand(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (ex_we && !ex_is_load && ex_wa == idx) return ex_wd;
      if (wb_we && wb_wa == idx) return wb_wd;
      return rf[idx];
   endfunction

   function automatic logic [31:0] addu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, 6'h21};
   endfunction

   task automatic model_reset();
      exp_valid = 1'b0;
      exp_pc = '0; exp_instr = '0; exp_rs = '0; exp_rt = '0; exp_cnt = '0;
   endtask

   task automatic check_outputs();
      chk("out_valid",   32'(pipe.out_valid), 32'(exp_valid));
      chk("out_pc",      pipe.out_pc,         exp_pc);
      chk("out_instr",   pipe.out_instr,      exp_instr);
      chk("out_rs_val",  pipe.out_rs_val,     exp_rs);
      chk("out_rt_val",  pipe.out_rt_val,     exp_rt);
      chk("stall_count", stall_count,         exp_cnt);
   endtask

   // One clock: drive, check combinational outputs, advance model, check registered outputs.
   task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl);
      logic [4:0] rs, rt;
      logic adv, hz, rdy;
      pipe.in_valid = v; pipe.in_instr = instr; pipe.in_pc = pc;
      pipe.out_ready = ordy; flush = fl;
      rs = instr[25:21];
      rt = instr[20:16];
      #1;
      adv = !exp_valid || ordy;
      hz  = v && ex_we && ex_is_load && ex_wa != 5'd0 &&
            ((m_uses_rs(instr[31:26]) && ex_wa == rs) || (m_uses_rt(instr[31:26]) && ex_wa == rt));
      rdy = adv && !hz && !fl;
      chk("in_ready", 32'(pipe.in_ready), 32'(rdy));
      chk("rf_ra1", 32'(rf_ra1), 32'(rs));
      chk("rf_ra2", 32'(rf_ra2), 32'(rt));
      if (v && rdy) begin
         exp_pc = pc; exp_instr = instr;
         exp_rs = m_operand(rs); exp_rt = m_operand(rt);
      end
`ifdef ID_STALL_COUNT_EN
      if (adv && hz && !fl) exp_cnt = exp_cnt + 32'd1;
`endif
      if (fl) exp_valid = 1'b0;
      else if (adv) exp_valid = v && rdy;
      @(posedge clk);
      if (wb_we && wb_wa != 5'd0) rf[wb_wa] = wb_wd;
      #1;
      check_outputs();
   endtask

   task automatic quiet_bypass();
      ex_we = 0; ex_is_load = 0; ex_wa = 0; ex_wd = 0;
      wb_we = 0; wb_wa = 0; wb_wd = 0;
   endtask

   logic [5:0] ops [10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0F, 6'h23, 6'h28, 6'h2B, 6'h08};

   initial begin
      logic [31:0] ins;
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
      rf[1] = 32'h11;
      quiet_bypass();
      flush = 0;
      rst_n = 0;
      pipe.in_valid = 1; pipe.in_instr = addu(1, 2, 3); pipe.in_pc = 32'h100; pipe.out_ready = 1;
      model_reset();
      #12;
      chk("rst_valid", 32'(pipe.out_valid), 32'd0);
      chk("rst_pc", pipe.out_pc, 32'd0);
      chk("rst_rs", pipe.out_rs_val, 32'd0);
      chk("rst_cnt", stall_count, 32'd0);
      rst_n = 1;

      // ADDU $3,$1,$2 after reset
      step(1, addu(1, 2, 3), 32'h100, 1, 0);
      chk("rst_accept", 32'(pipe.out_valid), 32'd1);

      // WB bypass, then EX over WB
      wb_we = 1; wb_wa = 1; wb_wd = 32'hAA;
      step(1, addu(1, 0, 4), 32'h104, 1, 0);
      chk("wb_bypass", pipe.out_rs_val, 32'hAA);
      ex_we = 1; ex_wa = 1; ex_wd = 32'hBB;
      step(1, addu(1, 0, 4), 32'h108, 1, 0);
      chk("ex_priority", pipe.out_rs_val, 32'hBB);

      // load-use on $5: one bubble, then WB delivers
      quiet_bypass();
      ex_we = 1; ex_is_load = 1; ex_wa = 5;
      step(1, addu(5, 0, 6), 32'h10C, 1, 0);
      chk("lu_bubble", 32'(pipe.out_valid), 32'd0);
      quiet_bypass();
      wb_we = 1; wb_wa = 5; wb_wd = 32'h1234;
      step(1, addu(5, 0, 6), 32'h10C, 1, 0);
      chk("lu_value", pipe.out_rs_val, 32'h1234);
`ifdef ID_STALL_COUNT_EN
      chk("lu_count", stall_count, 32'd1);
`else
      chk("lu_count", stall_count, 32'd0);
`endif

      // no false stall: LUI ignores rs/rt; load to $0 never stalls
      quiet_bypass();
      ex_we = 1; ex_is_load = 1; ex_wa = 5;
      step(1, {6'h0F, 5'd5, 5'd5, 16'h1234}, 32'h110, 1, 0);
      chk("lui_nostall", 32'(pipe.out_valid), 32'd1);
      ex_wa = 0;
      step(1, addu(0, 0, 7), 32'h114, 1, 0);
      chk("r0_nostall", 32'(pipe.out_valid), 32'd1);

      // backpressure
      quiet_bypass();
      step(1, addu(2, 3, 8), 32'h200, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, addu(3, 4, 9), 32'h204, 0, 0);
         chk("bp_hold", pipe.out_pc, 32'h200);
      end
      step(1, addu(3, 4, 9), 32'h204, 1, 0);
      chk("bp_release", pipe.out_pc, 32'h204);

      // flush while stalled
      ex_we = 1; ex_is_load = 1; ex_wa = 6;
      step(1, addu(1, 6, 2), 32'h300, 1, 0);
      step(1, addu(1, 6, 2), 32'h300, 1, 1);
      chk("flush_kill", 32'(pipe.out_valid), 32'd0);
      quiet_bypass();
      step(1, addu(1, 2, 3), 32'h400, 1, 0);
      chk("flush_recover", pipe.out_pc, 32'h400);

      // async reset in the middle of a stall
      ex_we = 1; ex_is_load = 1; ex_wa = 7;
      step(1, addu(7, 0, 1), 32'h500, 1, 0);
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("midrst_valid", 32'(pipe.out_valid), 32'd0);
      chk("midrst_cnt", stall_count, 32'd0);
      #2 rst_n = 1;
      quiet_bypass();
      step(1, addu(7, 0, 1), 32'h500, 1, 0);
      chk("midrst_reissue", pipe.out_pc, 32'h500);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         ex_we = $urandom_range(0, 1);
         ex_is_load = ($urandom_range(0, 9) < 3);
         ex_wa = 5'($urandom_range(0, 7));
         ex_wd = $urandom;
         wb_we = $urandom_range(0, 1);
         wb_wa = 5'($urandom_range(0, 7));
         wb_wd = $urandom;
         ins = {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom)};
         step(1'($urandom_range(0, 3) != 0), ins, $urandom,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
